// File: rtl/cpu4_pkg.sv
// cpu4_pkg: shared constants and types for the 4-bit CPU.
//   Opcode encodings, ALU select encodings, sequencer FSM states and
//   the decoded control bundle shared by instr_decode and instr_sequencer.
package cpu4_pkg;

  localparam int unsigned OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_LDI  = 4'b0000;
  localparam logic [OPC_W-1:0] OP_ADDI = 4'b0011;
  localparam logic [OPC_W-1:0] OP_LDA  = 4'b0101;
  localparam logic [OPC_W-1:0] OP_JMP  = 4'b1000;
  localparam logic [OPC_W-1:0] OP_JNC  = 4'b1001;
  localparam logic [OPC_W-1:0] OP_STA  = 4'b1010;
  localparam logic [OPC_W-1:0] OP_SUBI = 4'b1100;

  localparam logic [1:0] ALU_IMM = 2'd0;
  localparam logic [1:0] ALU_ADD = 2'd1;
  localparam logic [1:0] ALU_SUB = 2'd2;
  localparam logic [1:0] ALU_MEM = 2'd3;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  typedef struct packed {
    logic       acc_we;
    logic [1:0] alu_op;
    logic       mem_re;
    logic       mem_we;
    logic       is_jmp;
    logic       is_jnc;
  } ctrl_t;

endpackage

// File: rtl/instr_decode.sv
// instr_decode: combinational opcode decoder.
//   i_opcode : latched opcode nibble
//   o_ctrl   : {acc_we, alu_op, mem_re, mem_we, is_jmp, is_jnc}
module instr_decode
  import cpu4_pkg::*;
(
  input  logic [OPC_W-1:0] i_opcode,
  output ctrl_t            o_ctrl
);

  // Unlisted opcodes fall through as NOP.
  always_comb begin
    o_ctrl = '0;
    case (i_opcode)
      OP_LDI:  begin o_ctrl.acc_we = 1'b1; o_ctrl.alu_op = ALU_IMM; end
      OP_ADDI: begin o_ctrl.acc_we = 1'b1; o_ctrl.alu_op = ALU_ADD; end
      OP_SUBI: begin o_ctrl.acc_we = 1'b1; o_ctrl.alu_op = ALU_SUB; end
      OP_LDA:  begin
        o_ctrl.mem_re = 1'b1;
        o_ctrl.acc_we = 1'b1;
        o_ctrl.alu_op = ALU_MEM;
      end
      OP_STA:  o_ctrl.mem_we = 1'b1;
      OP_JMP:  o_ctrl.is_jmp = 1'b1;
      OP_JNC:  o_ctrl.is_jnc = 1'b1;
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/sequence stage of the 4-bit CPU.
//   CLK, RST        : clock, synchronous active-high reset
//   pc              : registered ROM address
//   rom_a, rom_d    : opcode / immediate nibbles from ROM at pc
//   carry_flag      : datapath carry, sampled on the completing EXEC cycle
//   stall           : holds EXEC while high
//   imm             : latched immediate (RAM address)
//   acc_we, alu_op,
//   mem_re, mem_we  : datapath strobes, valid only in EXEC
//   halted          : set after a jump-to-self
module instr_sequencer
  import cpu4_pkg::*;
#(
  parameter int unsigned PC_W  = 4,
  parameter int unsigned OP_W  = 4,
  parameter int unsigned IMM_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  output logic [PC_W-1:0]  pc,
  input  logic [OP_W-1:0]  rom_a,
  input  logic [IMM_W-1:0] rom_d,
  input  logic             carry_flag,
  input  logic             stall,
  output logic [IMM_W-1:0] imm,
  output logic             acc_we,
  output logic [1:0]       alu_op,
  output logic             mem_re,
  output logic             mem_we,
  output logic             halted
);

  localparam int unsigned IR_W = OP_W + IMM_W;

  logic [1:0]      r_state;
  logic [PC_W-1:0] r_pc;
  logic [IR_W-1:0] r_ir;
  logic            r_halted;

  logic [1:0]      w_state_nxt;
  logic [PC_W-1:0] w_pc_nxt;
  logic [IR_W-1:0] w_ir_nxt;
  logic [PC_W-1:0] w_target;
  logic            w_take;
  logic            w_exec;
  ctrl_t           w_ctrl;

  instr_decode u_decode (
    .i_opcode (OPC_W'(r_ir[IR_W-1:IMM_W])),
    .o_ctrl   (w_ctrl)
  );

  // State, pc and IR registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_FETCH;
      r_pc     <= '0;
      r_ir     <= '0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_ir     <= w_ir_nxt;
      r_halted <= (w_state_nxt == ST_HALT);
    end
  end

  // Next-state logic; jump resolution happens only when EXEC completes.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_target    = PC_W'(r_ir[IMM_W-1:0]);
    w_take      = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_ir_nxt    = {rom_a, rom_d};
        w_state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        if (!stall) begin
          w_take = w_ctrl.is_jmp | (w_ctrl.is_jnc & ~carry_flag);
          if (w_take && (w_target == r_pc)) begin
            w_state_nxt = ST_HALT;
          end else begin
            w_pc_nxt    = w_take ? w_target : r_pc + PC_W'(1);
            w_state_nxt = ST_FETCH;
          end
        end
      end
      ST_HALT:  w_state_nxt = ST_HALT;
      default:  w_state_nxt = ST_FETCH;
    endcase
  end

  // Strobes come from the registered IR and state, gated to EXEC.
  assign w_exec = (r_state == ST_EXEC);
  assign acc_we = w_exec & w_ctrl.acc_we;
  assign alu_op = w_exec ? w_ctrl.alu_op : ALU_IMM;
  assign mem_re = w_exec & w_ctrl.mem_re;
  assign mem_we = w_exec & w_ctrl.mem_we;

  assign pc     = r_pc;
  assign imm    = r_ir[IMM_W-1:0];
  assign halted = r_halted;

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] pc;
  logic [3:0] rom_a;
  logic [3:0] rom_d;
  logic       carry_flag;
  logic       stall;
  logic [3:0] imm;
  logic       acc_we;
  logic [1:0] alu_op;
  logic       mem_re;
  logic       mem_we;
  logic       halted;

  logic [7:0] rom [16];
  logic [7:0] rom_word;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  assign rom_word = rom[pc];
  assign rom_a    = rom_word[7:4];
  assign rom_d    = rom_word[3:0];

  instr_sequencer dut (
    .CLK        (CLK),
    .RST        (RST),
    .pc         (pc),
    .rom_a      (rom_a),
    .rom_d      (rom_d),
    .carry_flag (carry_flag),
    .stall      (stall),
    .imm        (imm),
    .acc_we     (acc_we),
    .alu_op     (alu_op),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .halted     (halted)
  );

  typedef struct {
    logic       stall;
    logic       carry;
    logic [3:0] pc;
    logic [3:0] imm;
    logic       acc_we;
    logic [1:0] alu;
    logic       mem_re;
    logic       mem_we;
    logic       halted;
  } vec_t;

  vec_t vecs [26];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input int idx,
                       input logic [3:0] e_pc, input logic [3:0] e_imm,
                       input logic e_we, input logic [1:0] e_alu,
                       input logic e_re, input logic e_mw, input logic e_h);
    total++;
    if (pc !== e_pc || imm !== e_imm || acc_we !== e_we || alu_op !== e_alu ||
        mem_re !== e_re || mem_we !== e_mw || halted !== e_h) begin
      bad++;
      $display("FAIL %s[%0d]: got pc=%0d imm=%0d acc_we=%b alu=%0d mem_re=%b mem_we=%b halted=%b, want pc=%0d imm=%0d acc_we=%b alu=%0d mem_re=%b mem_we=%b halted=%b",
               name, idx, pc, imm, acc_we, alu_op, mem_re, mem_we, halted,
               e_pc, e_imm, e_we, e_alu, e_re, e_mw, e_h);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'h70;
    rom[0]  = 8'h04;  // LDI 4
    rom[1]  = 8'hA2;  // STA 2
    rom[2]  = 8'h33;  // ADDI 3
    rom[3]  = 8'hC1;  // SUBI 1
    rom[4]  = 8'h55;  // LDA 5
    rom[5]  = 8'h89;  // JMP 9
    rom[9]  = 8'h9D;  // JNC 13
    rom[13] = 8'h89;  // JMP 9
    rom[10] = 8'h8F;  // JMP 15
    rom[15] = 8'h70;  // NOP

    //           stall carry pc     imm    we alu    re mw h
    vecs[0]  = '{0, 0, 4'd0,  4'd4,  1, 2'd0, 0, 0, 0};
    vecs[1]  = '{0, 0, 4'd1,  4'd4,  0, 2'd0, 0, 0, 0};
    vecs[2]  = '{0, 0, 4'd1,  4'd2,  0, 2'd0, 0, 1, 0};
    vecs[3]  = '{1, 0, 4'd1,  4'd2,  0, 2'd0, 0, 1, 0};
    vecs[4]  = '{1, 0, 4'd1,  4'd2,  0, 2'd0, 0, 1, 0};
    vecs[5]  = '{1, 0, 4'd1,  4'd2,  0, 2'd0, 0, 1, 0};
    vecs[6]  = '{0, 0, 4'd2,  4'd2,  0, 2'd0, 0, 0, 0};
    vecs[7]  = '{0, 0, 4'd2,  4'd3,  1, 2'd1, 0, 0, 0};
    vecs[8]  = '{0, 0, 4'd3,  4'd3,  0, 2'd0, 0, 0, 0};
    vecs[9]  = '{0, 0, 4'd3,  4'd1,  1, 2'd2, 0, 0, 0};
    vecs[10] = '{0, 0, 4'd4,  4'd1,  0, 2'd0, 0, 0, 0};
    vecs[11] = '{0, 0, 4'd4,  4'd5,  1, 2'd3, 1, 0, 0};
    vecs[12] = '{0, 0, 4'd5,  4'd5,  0, 2'd0, 0, 0, 0};
    vecs[13] = '{0, 0, 4'd5,  4'd9,  0, 2'd0, 0, 0, 0};
    vecs[14] = '{0, 0, 4'd9,  4'd9,  0, 2'd0, 0, 0, 0};
    vecs[15] = '{0, 1, 4'd9,  4'd13, 0, 2'd0, 0, 0, 0};
    vecs[16] = '{1, 1, 4'd9,  4'd13, 0, 2'd0, 0, 0, 0};
    vecs[17] = '{0, 0, 4'd13, 4'd13, 0, 2'd0, 0, 0, 0};
    vecs[18] = '{0, 0, 4'd13, 4'd9,  0, 2'd0, 0, 0, 0};
    vecs[19] = '{0, 0, 4'd9,  4'd9,  0, 2'd0, 0, 0, 0};
    vecs[20] = '{0, 0, 4'd9,  4'd13, 0, 2'd0, 0, 0, 0};
    vecs[21] = '{0, 1, 4'd10, 4'd13, 0, 2'd0, 0, 0, 0};
    vecs[22] = '{0, 0, 4'd10, 4'd15, 0, 2'd0, 0, 0, 0};
    vecs[23] = '{0, 0, 4'd15, 4'd15, 0, 2'd0, 0, 0, 0};
    vecs[24] = '{0, 0, 4'd15, 4'd0,  0, 2'd0, 0, 0, 0};
    vecs[25] = '{0, 0, 4'd0,  4'd0,  0, 2'd0, 0, 0, 0};

    RST = 1'b1; stall = 1'b0; carry_flag = 1'b0;
    tick();
    tick();
    check("reset", 0, 4'd0, 4'd0, 0, 2'd0, 0, 0, 0);
    RST = 1'b0;

    for (int i = 0; i < 26; i++) begin
      stall      = vecs[i].stall;
      carry_flag = vecs[i].carry;
      tick();
      check("prog", i, vecs[i].pc, vecs[i].imm, vecs[i].acc_we, vecs[i].alu,
            vecs[i].mem_re, vecs[i].mem_we, vecs[i].halted);
    end

    // Jump-to-self at pc=15 halts; only reset recovers.
    RST = 1'b1; stall = 1'b0; carry_flag = 1'b0;
    tick();
    rom[0]  = 8'h8F;
    rom[15] = 8'h8F;
    RST = 1'b0;
    tick(); check("halt_seq", 0, 4'd0,  4'd15, 0, 2'd0, 0, 0, 0);
    tick(); check("halt_seq", 1, 4'd15, 4'd15, 0, 2'd0, 0, 0, 0);
    tick(); check("halt_seq", 2, 4'd15, 4'd15, 0, 2'd0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("halted", i, 4'd15, 4'd15, 0, 2'd0, 0, 0, 1);
    end
    RST = 1'b1;
    tick(); check("halt_rst", 0, 4'd0, 4'd0, 0, 2'd0, 0, 0, 0);

    // Reset during a stalled LDA drops strobes immediately.
    rom[0] = 8'h55;
    RST = 1'b0; stall = 1'b1;
    tick(); check("lda_rst", 0, 4'd0, 4'd5, 1, 2'd3, 1, 0, 0);
    tick(); check("lda_rst", 1, 4'd0, 4'd5, 1, 2'd3, 1, 0, 0);
    RST = 1'b1;
    tick(); check("lda_rst", 2, 4'd0, 4'd0, 0, 2'd0, 0, 0, 0);
    RST = 1'b0; stall = 1'b0;
    tick(); check("lda_rst", 3, 4'd0, 4'd5, 1, 2'd3, 1, 0, 0);
    tick(); check("lda_rst", 4, 4'd1, 4'd5, 0, 2'd0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Fetch/decode/sequence stage of the 4-bit CPU; owns the program counter and drives the program ROM address.
- Latches the ROM's opcode nibble (A) and immediate nibble (D) into an instruction register.
- Decodes the latched instruction into one-cycle control strobes for the datapath (accumulator, ALU, RAM), and resolves jumps from datapath flags.
- Sits between the program ROM (upstream) and the datapath execute logic (downstream).

Parameters:
- PC_W, 4, program counter width; ROM depth is 2**PC_W.
- OP_W, 4, opcode field width (ROM A output).
- IMM_W, 4, immediate/address field width (ROM D output).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- pc  output  PC_W  ROM address; registered.
- rom_a  input  OP_W  opcode nibble from ROM at pc.
- rom_d  input  IMM_W  immediate nibble from ROM at pc.
- carry_flag  input  1  datapath carry flag, sampled in EXEC.
- stall  input  1  datapath/RAM busy; holds EXEC while high.
- imm  output  IMM_W  latched immediate; also the RAM address.
- acc_we  output  1  accumulator write strobe.
- alu_op  output  2  0 = pass imm, 1 = acc+imm, 2 = acc-imm, 3 = pass RAM data.
- mem_re  output  1  RAM read strobe.
- mem_we  output  1  RAM write strobe (stores acc at address imm).
- halted  output  1  high once a jump-to-self is executed.

Behaviour:
- FSM states: FETCH, EXEC, HALT. On reset: state=FETCH, pc=0, IR=0, halted=0. All strobes are 0 and imm=0.
- FETCH, one cycle: IR <= {rom_a, rom_d}; pc is held; all strobes are 0. Next state is EXEC.
- EXEC: strobes are decoded combinationally from IR and are valid only in EXEC.
  - 0000 LDI: acc_we=1, alu_op=0.
  - 0011 ADDI: acc_we=1, alu_op=1.
  - 1100 SUBI: acc_we=1, alu_op=2.
  - 0101 LDA: mem_re=1, acc_we=1, alu_op=3.
  - 1010 STA: mem_we=1.
  - 1000 JMP: no strobes.
  - 1001 JNC: no strobes.
  - All other opcodes are NOP: no strobes.
- stall=1 in EXEC: state, pc, and IR are held, and strobes stay asserted. The datapath qualifies its writes with !stall, so each strobe takes effect exactly once, in the final non-stalled EXEC cycle.
- EXEC completion (stall=0): pc is updated and state returns to FETCH.
  - JMP: pc <= imm.
  - JNC: pc <= imm if carry_flag=0, else pc+1.
  - All others: pc <= pc+1.
- pc arithmetic is modulo 2**PC_W: 15 -> 0 wrap is legal and silent.
- CPI: 2 cycles per instruction without stall; 2+N with N stall cycles.
- Halt detection: a taken JMP or JNC whose target equals the current pc enters HALT instead of FETCH. halted=1, pc stays frozen at that address, all strobes are 0. Only RST leaves HALT.
- carry_flag is sampled only in the completing EXEC cycle. Changes during stall cycles have no effect until then.
- RST wins over everything. RST asserted mid-EXEC (including while stalled) suppresses strobes in the following cycle: the next cycle is FETCH at pc=0.
- rom_a and rom_d are sampled only in FETCH. Changes at other times have no effect.

Decomposition:
- Shared package cpu4_pkg holds:
  - opcode constants: OP_LDI=0000, OP_ADDI=0011, OP_LDA=0101, OP_JMP=1000, OP_JNC=1001, OP_STA=1010, OP_SUBI=1100;
  - alu_op encodings: ALU_IMM, ALU_ADD, ALU_SUB, ALU_MEM;
  - FSM state encoding.
- One sub-module: instr_decode, purely combinational, mapping opcode to {acc_we, alu_op, mem_re, mem_we, is_jmp, is_jnc}. The sequencer gates its outputs with state==EXEC.

Test Plan:
- Reset then ROM[0]=0000_0100 (LDI 4): FETCH at pc=0, then EXEC with acc_we=1, alu_op=0, imm=4; pc=1 in the following cycle; strobes present for exactly 1 cycle.
- ROM[1]=1010_0010 (STA 2) with stall high for 3 cycles: mem_we=1 and imm=2 held 4 cycles; pc stays 1 until the stall drops, then becomes 2.
- JNC 13 at pc=9, twice: with carry_flag=0, pc goes 9 -> 13; with carry_flag=1, pc goes 9 -> 10; no strobes in either case.
- JMP at pc=15 with imm=15: halted=1, pc stays 15 for 20 cycles, all strobes 0. Then RST=1 for 1 cycle: halted=0, pc=0, state FETCH.
- NOP (opcode 0111) at pc=15: pc wraps to 0 after EXEC; no strobes asserted.
- RST asserted during a stalled LDA (mem_re=1): the next cycle has mem_re=0, acc_we=0, pc=0, FETCH.
